// File: rtl/instr_realign_q.sv
// Purpose : realigns fetch blocks into 16/32-bit instructions via a circular halfword queue.
// Latency : one cycle; a halfword pushed at edge N appears on instr_o after edge N.
// Backpr. : fetch_ready_o drops when fewer than NHW slots are free; instr_ready_i stalls the head.
// Ports   : clk_i/rst_i (async, active-high) | flush_i, flush_pc_i : redirect to a new PC
//           fetch_valid_i/fetch_ready_o/fetch_data_i : fetch block in, lowest halfword first
//           instr_valid_o/instr_ready_i/instr_o/instr_pc_o/instr_compressed_o : instruction out
module instr_realign_q #(
    parameter int FETCH_W = 32,
    parameter int QDEPTH  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [31:0]        flush_pc_i,
    input  logic               fetch_valid_i,
    input  logic [FETCH_W-1:0] fetch_data_i,
    output logic               fetch_ready_o,
    output logic               instr_valid_o,
    output logic [31:0]        instr_o,
    output logic [31:0]        instr_pc_o,
    output logic               instr_compressed_o,
    input  logic               instr_ready_i
);

    localparam int NHW    = FETCH_W / 16;
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int CNT_W  = $clog2(QDEPTH + 1);
    localparam int SKIP_W = $clog2(NHW);

    // Halfword storage; contents are never reset, occupancy is tracked by count_q.
    logic [15:0]       queue_q [QDEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [31:0]       pc_q, pc_d;

    logic [PTR_W-1:0]  rd_ptr_p1;
    logic [15:0]       head_hw;
    logic [15:0]       next_hw;
    logic              head_c;
    logic              instr_avail;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  push_n;
    logic [CNT_W-1:0]  pop_n;
    logic [CNT_W-1:0]  free_slots;

    logic [PTR_W-1:0]  wr_idx [NHW];
    logic              wr_en  [NHW];

    // Bit 0 of the redirect PC is architecturally meaningless.
    logic unused_pc_bit0;
    assign unused_pc_bit0 = flush_pc_i[0];

    // ------------------------------------------------------------------
    // Head decode: everything here depends on registered state only,
    // except the flush override, so fetch_* never reaches instr_*.
    // ------------------------------------------------------------------
    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
    assign head_hw   = queue_q[rd_ptr_q];
    assign next_hw   = queue_q[rd_ptr_p1];
    assign head_c    = (head_hw[1:0] != 2'b11);

    // A 32-bit head with only its low half queued waits for the next block.
    assign instr_avail = head_c ? (count_q >= CNT_W'(1)) : (count_q >= CNT_W'(2));

    assign instr_valid_o      = instr_avail && !flush_i;
    assign instr_compressed_o = head_c;
    assign instr_o            = head_c ? {16'h0000, head_hw} : {next_hw, head_hw};
    assign instr_pc_o         = pc_q;

    // ------------------------------------------------------------------
    // Fetch side: readiness comes from count_q and flush_i only, so
    // instr_ready_i has no path to fetch_ready_o.
    // ------------------------------------------------------------------
    assign free_slots    = CNT_W'(QDEPTH) - count_q;
    assign fetch_ready_o = (free_slots >= CNT_W'(NHW)) && !flush_i;

    // Both handshakes are already blocked by flush_i, which gives the
    // redirect priority over a simultaneous push or pop.
    assign push   = fetch_valid_i && fetch_ready_o;
    assign pop    = instr_valid_o && instr_ready_i;
    assign push_n = CNT_W'(NHW) - CNT_W'(skip_q);
    assign pop_n  = head_c ? CNT_W'(1) : CNT_W'(2);

    // Halfword i of the block lands at wr_ptr + (i - skip); the first
    // skip halfwords of a post-redirect block are dropped.
    always_comb begin
        for (int i = 0; i < NHW; i++) begin
            wr_idx[i] = wr_ptr_q + PTR_W'(i) - PTR_W'(skip_q);
            wr_en[i]  = push && (SKIP_W'(i) >= skip_q);
        end
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        skip_d   = skip_q;
        pc_d     = pc_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = {flush_pc_i[31:1], 1'b0};
            // Halfword offset of the target PC inside its fetch block.
            skip_d   = flush_pc_i[SKIP_W:1];
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
                skip_d   = '0;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
                pc_d     = pc_q + (head_c ? 32'd2 : 32'd4);
            end
            count_d = count_q + (push ? push_n : '0) - (pop ? pop_n : '0);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            skip_q   <= '0;
            pc_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            skip_q   <= skip_d;
            pc_q     <= pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NHW; i++) begin
            if (wr_en[i]) begin
                queue_q[wr_idx[i]] <= fetch_data_i[16*i +: 16];
            end
        end
    end

endmodule

// File: doc/instr_realign_q.md
INSTR_REALIGN_Q -- requirements
Module: instr_realign_q

Interface
REQ-001 Parameter FETCH_W, default 32, meaning fetch block width in bits; legal values 32 and 64.
REQ-002 Parameter QDEPTH, default 8, meaning halfword queue depth; power of two, at least 2*FETCH_W/16.
REQ-003 Derived value NHW = FETCH_W/16, meaning halfwords per fetch block.
REQ-004 clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 flush_i  in  1  redirect; discard all queued halfwords.
REQ-007 flush_pc_i  in  32  new fetch PC, applied with flush_i; bit 0 is ignored.
REQ-008 fetch_valid_i  in  1  fetch block valid.
REQ-009 fetch_data_i  in  FETCH_W  fetch block, lowest halfword first in program order.
REQ-010 fetch_ready_o  out  1  block can accept a fetch block.
REQ-011 instr_valid_o  out  1  instr_o holds a complete instruction.
REQ-012 instr_o  out  32  instruction; compressed instructions are zero-extended to {16'h0, hw}.
REQ-013 instr_pc_o  out  32  PC of instr_o.
REQ-014 instr_compressed_o  out  1  instr_o is a 16-bit instruction.
REQ-015 instr_ready_i  in  1  consumer accepts instr_o.

Function
REQ-016 Storage SHALL be a circular halfword queue with rd_ptr, wr_ptr, and count in 0..QDEPTH.
REQ-017 fetch_ready_o SHALL be 1 iff (QDEPTH - count) >= NHW and flush_i = 0, decoded from registered state only.
REQ-018 A push SHALL occur when fetch_valid_i and fetch_ready_o are both 1; it writes NHW halfwords minus skip, where skip is defined in REQ-025.
REQ-019 A halfword SHALL be compressed iff its bits [1:0] != 2'b11.
REQ-020 instr_valid_o SHALL be 1 iff count >= 1 and the head halfword is compressed, or count >= 2 and the head halfword is not compressed; flush_i = 1 forces it to 0.
REQ-021 instr_o SHALL be {queue[rd_ptr+1], queue[rd_ptr]} for a 32-bit instruction and {16'h0, queue[rd_ptr]} for a compressed one; it is don't-care when instr_valid_o = 0.
REQ-022 A pop SHALL occur when instr_valid_o and instr_ready_i are both 1; it advances rd_ptr by 1 for a compressed instruction and by 2 otherwise, modulo QDEPTH.
REQ-023 A pop SHALL advance instr_pc_o by 2 for a compressed instruction and by 4 otherwise, with 32-bit wrap-around.
REQ-024 A push and a pop in the same cycle SHALL both take effect; count_next = count + pushed - popped.
REQ-025 On flush_i: count SHALL become 0, rd_ptr and wr_ptr SHALL become 0, instr_pc_o SHALL become {flush_pc_i[31:1], 1'b0}, and skip SHALL be loaded with flush_pc_i[log2(FETCH_W/8)-1:1].
REQ-026 The skip value SHALL discard that many low halfwords of the first block pushed after a flush, then clear to 0.
REQ-027 flush_i SHALL take priority over a push and a pop in the same cycle; neither takes effect.
REQ-028 A 32-bit instruction whose low halfword is the last queued halfword SHALL be held, with instr_valid_o = 0, until the next push supplies its upper half; this is the block-straddling case.
REQ-029 Pointer wrap SHALL occur at QDEPTH with no bubble.
REQ-030 The queue SHALL never overflow or underflow; a push attempted while fetch_ready_o = 0 SHALL be ignored.
REQ-031 Latency SHALL be one cycle: a halfword pushed at edge N is visible on instr_o after edge N.
REQ-032 Throughput SHALL be one instruction per cycle when the queue is non-empty and instr_ready_i = 1.
REQ-033 There SHALL be no combinational path from fetch_* inputs to instr_* outputs, or from instr_ready_i to fetch_ready_o.

Reset
REQ-034 While rst_i = 1: count = 0, pointers = 0, skip = 0, instr_pc_o = 32'h0, instr_valid_o = 0, fetch_ready_o = 1.
REQ-035 Reset asserted mid-operation SHALL drop all queued halfwords immediately, with no partial pop.
REQ-036 Queue storage contents are not reset.

Verification
REQ-037 FETCH_W=32: push 32'h4501_0001 at PC 0 -> two compressed instructions: 32'h0001 at PC 0, then 32'h4501 at PC 2, one per cycle.
REQ-038 FETCH_W=32: push 32'h0513_4501, then 32'h0085_0000 -> 32'h4501 (C) at PC 0, then 32'h0000_0513 at PC 2; the straddling instruction is not valid until the second push.
REQ-039 FETCH_W=64, flush_pc_i = 32'h106 -> skip = 3; only the top halfword of the first block is queued; the first instr_pc_o is 32'h106.
REQ-040 Hold instr_ready_i = 0 and push until full (QDEPTH=8, FETCH_W=32, 4 pushes) -> fetch_ready_o = 0 with count = 8; release -> draining in order, with pointer wrap checked.
REQ-041 flush_i in the same cycle as a push and a pop -> count = 0, pc = flush_pc_i, neither the push nor the pop takes effect; rst_i pulsed mid-stream -> instr_valid_o = 0 asynchronously.
